// File: rtl/oam_dma_master_if.sv
// rtl/oam_dma_master_if.sv - arbiter handshake, address and strobes of the CPU-side memory bus
interface oam_dma_master_if;
    logic        I_BUS_GNT;
    logic        O_BUS_REQ;
    logic [15:0] O_ADDR;
    logic        O_RE_L;
    logic        O_WE_L;

    modport master (input I_BUS_GNT, output O_BUS_REQ, O_ADDR, O_RE_L, O_WE_L);
    modport slave  (output I_BUS_GNT, input O_BUS_REQ, O_ADDR, O_RE_L, O_WE_L);
endinterface

// File: rtl/oam_dma_master.sv
// rtl/oam_dma_master.sv - OAM DMA bus initiator copying one source page to OAM
// Optional feature: define OAM_DMA_RESTART_EN to let I_START restart a transfer in progress.
module oam_dma_master #(
    parameter int unsigned P_LEN      = 160,
    parameter logic [15:0] P_DST_BASE = 16'hFE00,
    parameter int unsigned P_RD_LAT   = 2
) (
    input  logic             I_CLK,
    input  logic             I_RESET,
    input  logic             I_START,
    input  logic [7:0]       I_SRC_PAGE,
    oam_dma_master_if.master bus,
    output logic             O_BUSY,
    output logic             O_DONE,
    inout  wire  [7:0]       IO_DATA
);
    typedef enum logic [2:0] {IDLE, REQ, RD, WR, DONE} state_t;

    localparam int unsigned RL_W    = (P_RD_LAT > 1) ? $clog2(P_RD_LAT) : 1;
    localparam logic [8:0]  LAST    = 9'(P_LEN - 1);
    localparam logic [RL_W-1:0] RD_LAST = RL_W'(P_RD_LAT - 1);

    state_t          state, state_nxt;
    logic [7:0]      page, page_nxt;
    logic [8:0]      cnt, cnt_nxt;
    logic [RL_W-1:0] rd_cnt, rd_cnt_nxt;
    logic [7:0]      data_q, data_nxt;
    logic            pend, pend_nxt;
    logic            drive;

    // Echo RAM E000-FDFF mirrors C000-DDFF
    function automatic logic [7:0] map_page(input logic [7:0] p);
        return (p >= 8'hE0) ? (p - 8'h20) : p;
    endfunction

    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            state  <= IDLE;
            page   <= 8'h00;
            cnt    <= 9'd0;
            rd_cnt <= '0;
            data_q <= 8'h00;
            pend   <= 1'b0;
        end else begin
            state  <= state_nxt;
            page   <= page_nxt;
            cnt    <= cnt_nxt;
            rd_cnt <= rd_cnt_nxt;
            data_q <= data_nxt;
            pend   <= pend_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        page_nxt      = page;
        cnt_nxt       = cnt;
        rd_cnt_nxt    = rd_cnt;
        data_nxt      = data_q;
        pend_nxt      = pend;
        bus.O_BUS_REQ = 1'b0;
        bus.O_ADDR    = 16'h0000;
        bus.O_RE_L    = 1'b1;
        bus.O_WE_L    = 1'b1;
        O_BUSY        = 1'b0;
        O_DONE        = 1'b0;
        drive         = 1'b0;

        case (state)
            IDLE: begin
                if (I_START) begin
                    page_nxt  = map_page(I_SRC_PAGE);
                    cnt_nxt   = 9'd0;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                bus.O_BUS_REQ = 1'b1;
                O_BUSY        = 1'b1;
                if (bus.I_BUS_GNT) begin
                    rd_cnt_nxt = '0;
                    state_nxt  = RD;
                end
            end
            RD: begin
                bus.O_BUS_REQ = 1'b1;
                O_BUSY        = 1'b1;
                bus.O_ADDR    = {page, cnt[7:0]};
                bus.O_RE_L    = 1'b0;
                if (rd_cnt == RD_LAST) begin
                    data_nxt  = IO_DATA;
                    state_nxt = WR;
                end else begin
                    rd_cnt_nxt = rd_cnt + 1'b1;
                end
            end
            WR: begin
                bus.O_BUS_REQ = 1'b1;
                O_BUSY        = 1'b1;
                bus.O_ADDR    = P_DST_BASE + {7'd0, cnt};
                bus.O_WE_L    = 1'b0;
                drive         = 1'b1;
                if (cnt == LAST) begin
                    state_nxt = DONE;
                end else begin
                    // grant is only re-checked here, between bytes
                    cnt_nxt    = cnt + 9'd1;
                    rd_cnt_nxt = '0;
                    state_nxt  = bus.I_BUS_GNT ? RD : REQ;
                end
            end
            DONE: begin
                O_DONE   = 1'b1;
                pend_nxt = 1'b0;
                if (I_START || pend) begin
                    if (I_START) page_nxt = map_page(I_SRC_PAGE);
                    cnt_nxt   = 9'd0;
                    state_nxt = REQ;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

`ifdef OAM_DMA_RESTART_EN
        // A start landing on the final write lets that transfer finish and restarts after DONE
        if (I_START && O_BUSY) begin
            page_nxt = map_page(I_SRC_PAGE);
            if (state == WR && cnt == LAST) begin
                pend_nxt = 1'b1;
            end else begin
                cnt_nxt   = 9'd0;
                state_nxt = REQ;
            end
        end
`else
        pend_nxt = 1'b0;
`endif
    end

    assign IO_DATA = drive ? data_q : 8'bzzzzzzzz;
endmodule

// File: tb/tb_oam_dma_master.sv
// tb/tb_oam_dma_master.sv - scoreboard bench for oam_dma_master
module tb_oam_dma_master;
    localparam logic [7:0] PROBE = 8'hC3;

    typedef struct packed {
        logic [15:0] a;
        logic [7:0]  d;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] src_page = 8'h00;
    logic       gnt = 1'b1;
    logic       busy, done;
    wire  [7:0] io_data;

    logic [7:0] mem [0:65535];
    logic       tb_en;
    logic [7:0] tb_val;

    exp_t sb[$];
    exp_t e;
    int   total = 0;
    int   bad = 0;
    int   done_cnt = 0;

    oam_dma_master_if bus();
    assign bus.I_BUS_GNT = gnt;

    oam_dma_master dut (
        .I_CLK      (clk),
        .I_RESET    (rst),
        .I_START    (start),
        .I_SRC_PAGE (src_page),
        .bus        (bus.master),
        .O_BUSY     (busy),
        .O_DONE     (done),
        .IO_DATA    (io_data)
    );

    always #5 clk = ~clk;

    // Memory answers reads; otherwise a probe value exposes any stray DUT drive
    always_comb begin
        tb_en  = bus.O_WE_L;
        tb_val = (bus.O_RE_L == 1'b0) ? mem[bus.O_ADDR] : PROBE;
    end
    assign io_data = tb_en ? tb_val : 8'hzz;

    function automatic logic [7:0] pat(input logic [15:0] a);
        case (a[15:8])
            8'hC0:   pat = a[7:0] ^ 8'h5A;
            8'hC1:   pat = a[7:0] ^ 8'hA5;
            8'hD0:   pat = a[7:0] + 8'h11;
            8'hE1:   pat = 8'hEE;
            default: pat = a[7:0] ^ a[15:8];
        endcase
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.O_WE_L == 1'b0) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_write addr=%h data=%h required=no write", bus.O_ADDR, io_data);
                end else begin
                    e = sb.pop_front();
                    if ({bus.O_ADDR, io_data} !== {e.a, e.d}) begin
                        bad++;
                        $display("FAIL write addr=%h data=%h required addr=%h data=%h", bus.O_ADDR, io_data, e.a, e.d);
                    end
                end
            end
            if (done) done_cnt++;
            total++;
            if ((!bus.O_RE_L && !bus.O_WE_L) || ((!bus.O_RE_L || !bus.O_WE_L) && !bus.O_BUS_REQ)) begin
                bad++;
                $display("FAIL protocol_strobes re_l=%b we_l=%b req=%b required no overlap and req=1", bus.O_RE_L, bus.O_WE_L, bus.O_BUS_REQ);
            end
            total++;
            if (bus.O_WE_L && io_data !== tb_val) begin
                bad++;
                $display("FAIL protocol_data_z io_data=%h required=%h (DUT undriven)", io_data, tb_val);
            end
        end
    end

    task automatic push_copy(input logic [7:0] p);
        logic [7:0] sp;
        exp_t x;
        sp = (p >= 8'hE0) ? (p - 8'h20) : p;
        for (int i = 0; i < 160; i++) begin
            x.a = 16'hFE00 + 16'(i);
            x.d = pat({sp, 8'(i)});
            sb.push_back(x);
        end
    endtask

    task automatic kick(input logic [7:0] p);
        push_copy(p);
        start = 1'b1;
        src_page = p;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_until_done(input int budget, output int n);
        n = 0;
        while (n < budget) begin
            @(posedge clk); #1;
            n++;
            if (done) return;
        end
        n = -1;
    endtask

    task automatic wait_rd(input logic [7:0] b, input int budget, output int n);
        n = 0;
        while (n < budget) begin
            @(posedge clk); #1;
            n++;
            if (!bus.O_RE_L && bus.O_ADDR[7:0] == b) return;
        end
        n = -1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({busy, done, bus.O_BUS_REQ} !== 3'b000) begin
            bad++;
            $display("FAIL reset_flags busy/done/req=%b required=000", {busy, done, bus.O_BUS_REQ});
        end
        total++;
        if ({bus.O_ADDR, bus.O_RE_L, bus.O_WE_L} !== {16'h0000, 2'b11}) begin
            bad++;
            $display("FAIL reset_bus addr=%h re_l=%b we_l=%b required addr=0000 re_l=1 we_l=1", bus.O_ADDR, bus.O_RE_L, bus.O_WE_L);
        end
        total++;
        if (io_data !== PROBE) begin
            bad++;
            $display("FAIL reset_data_z io_data=%h required=%h", io_data, PROBE);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int n;
        done_cnt = 0;
        kick(8'hC0);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL basic_busy_rise busy=%b required=1", busy);
        end
        run_until_done(700, n);
        total++;
        if (n < 478 || n > 482) begin
            bad++;
            $display("FAIL basic_latency cycles=%0d required=480+/-2", n);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL basic_busy_at_done busy=%b required=0", busy);
        end
        repeat (4) @(posedge clk);
        #1;
        total++;
        if (done_cnt != 1 || sb.size() != 0) begin
            bad++;
            $display("FAIL basic_completion done_pulses=%0d left=%0d required 1 and 0", done_cnt, sb.size());
        end
    endtask

    task automatic test_echo();
        int n;
        int bad_src;
        int seen;
        done_cnt = 0;
        bad_src = 0;
        seen = 0;
        n = 0;
        kick(8'hE1);
        repeat (700) begin
            @(posedge clk); #1;
            n++;
            if (!bus.O_RE_L) begin
                seen++;
                if (bus.O_ADDR[15:8] !== 8'hC1) bad_src++;
            end
            if (done) break;
        end
        total++;
        if (bad_src != 0 || seen != 320) begin
            bad++;
            $display("FAIL echo_src wrong_page_reads=%0d rd_cycles=%0d required 0 and 320", bad_src, seen);
        end
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (done_cnt != 1 || sb.size() != 0) begin
            bad++;
            $display("FAIL echo_completion done_pulses=%0d left=%0d required 1 and 0", done_cnt, sb.size());
        end
    endtask

    task automatic test_grant_drop();
        int n;
        int m;
        done_cnt = 0;
        kick(8'hC0);
        wait_rd(8'd5, 100, n);
        total++;
        if (n < 0) begin
            bad++;
            $display("FAIL gnt_wait_byte5 timeout=%0d required byte 5 read", n);
        end
        gnt = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            n++;
        end
        total++;
        if ({bus.O_BUS_REQ, busy, bus.O_RE_L, bus.O_WE_L} !== 4'b1111) begin
            bad++;
            $display("FAIL gnt_hold req/busy/re_l/we_l=%b required=1111", {bus.O_BUS_REQ, busy, bus.O_RE_L, bus.O_WE_L});
        end
        total++;
        if (sb.size() != 154) begin
            bad++;
            $display("FAIL gnt_byte5_done left=%0d required=154", sb.size());
        end
        gnt = 1'b1;
        wait_rd(8'd6, 20, m);
        total++;
        if (m < 0 || bus.O_ADDR !== 16'hC006) begin
            bad++;
            $display("FAIL gnt_resume addr=%h wait=%0d required addr=C006", bus.O_ADDR, m);
        end
        n += m;
        run_until_done(700, m);
        n = (m < 0) ? -1 : n + m;
        total++;
        if (n < 487 || n > 493) begin
            bad++;
            $display("FAIL gnt_latency cycles=%0d required about 490", n);
        end
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (done_cnt != 1 || sb.size() != 0) begin
            bad++;
            $display("FAIL gnt_completion done_pulses=%0d left=%0d required 1 and 0", done_cnt, sb.size());
        end
    endtask

    task automatic test_reset_mid();
        int n;
        done_cnt = 0;
        kick(8'hC0);
        wait_rd(8'd40, 200, n);
        total++;
        if (n < 0) begin
            bad++;
            $display("FAIL rst_wait_byte40 timeout=%0d required byte 40 read", n);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({busy, done, bus.O_BUS_REQ, bus.O_ADDR, bus.O_RE_L, bus.O_WE_L} !== {3'b000, 16'h0000, 2'b11}) begin
            bad++;
            $display("FAIL rst_mid_outputs busy=%b done=%b req=%b addr=%h re_l=%b we_l=%b required 0 0 0 0000 1 1",
                     busy, done, bus.O_BUS_REQ, bus.O_ADDR, bus.O_RE_L, bus.O_WE_L);
        end
        total++;
        if (io_data !== PROBE) begin
            bad++;
            $display("FAIL rst_mid_data_z io_data=%h required=%h", io_data, PROBE);
        end
        sb.delete();
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        total++;
        if (done_cnt != 0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_no_done done_pulses=%0d busy=%b required 0 and 0", done_cnt, busy);
        end
        kick(8'hC1);
        run_until_done(700, n);
        total++;
        if (n < 478 || n > 482) begin
            bad++;
            $display("FAIL rst_rerun_latency cycles=%0d required=480+/-2", n);
        end
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (done_cnt != 1 || sb.size() != 0) begin
            bad++;
            $display("FAIL rst_rerun_completion done_pulses=%0d left=%0d required 1 and 0", done_cnt, sb.size());
        end
    endtask

    task automatic test_restart();
        int n;
        done_cnt = 0;
        kick(8'hC0);
        wait_rd(8'd80, 400, n);
        total++;
        if (n < 0) begin
            bad++;
            $display("FAIL restart_wait_byte80 timeout=%0d required byte 80 read", n);
        end
`ifdef OAM_DMA_RESTART_EN
        sb.delete();
        push_copy(8'hD0);
`endif
        start = 1'b1;
        src_page = 8'hD0;
        @(posedge clk); #1;
        start = 1'b0;
        run_until_done(900, n);
        total++;
        if (n < 0) begin
            bad++;
            $display("FAIL restart_done timeout=%0d required a DONE pulse", n);
        end
        repeat (20) @(posedge clk);
        #1;
        total++;
        if (done_cnt != 1 || sb.size() != 0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL restart_completion done_pulses=%0d left=%0d busy=%b required 1 0 0", done_cnt, sb.size(), busy);
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = pat(16'(i));
        test_reset();
        test_basic();
        test_echo();
        test_grant_drop();
        test_reset_mid();
        test_restart();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
